fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have these parameters: RESET_PC, 32'h0000_0000, first fetch address; FIFO_DEPTH, 2, prefetch buffer entries (fixed at 2).
REQ-002 The block SHALL have these ports: clk  in  1  rising-edge clock.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 stall  in  1  downstream hold; IF/ID register must keep its value.
REQ-005 br_taken  in  1  redirect request from execute.
REQ-006 br_target  in  32  redirect address.
REQ-007 imem_req  out  1  instruction memory request.
REQ-008 imem_addr  out  32  word-aligned request address.
REQ-009 imem_ready  in  1  one-cycle pulse; imem_rdata valid.
REQ-010 imem_rdata  in  32  returned instruction.
REQ-011 ifid_load  out  1  load enable for the 32-bit IF/ID pipeline registers.
REQ-012 ifid_instr  out  32  instruction to IF/ID; 32'h0 = NOP bubble.
REQ-013 ifid_pc4  out  32  fetch PC + 4 of ifid_instr.

Function
REQ-014 PC SHALL advance by 4 on each accepted request and wrap modulo 2^32.
REQ-015 Request FSM SHALL have states IDLE, WAIT, DISCARD.
REQ-016 IDLE->WAIT: when occupancy (FIFO count + outstanding) < 2 and no br_taken; imem_req=1, imem_addr=PC.
REQ-017 WAIT: imem_req and imem_addr SHALL stay stable until imem_ready; on imem_ready push {rdata, addr+4}, go IDLE.
REQ-018 br_taken in IDLE: PC<=br_target, FIFO cleared, stay IDLE.
REQ-019 br_taken in WAIT without imem_ready: PC<=br_target, FIFO cleared, go DISCARD.
REQ-020 br_taken in WAIT with imem_ready same cycle: returned data dropped, PC<=br_target, FIFO cleared, go IDLE.
REQ-021 DISCARD: imem_req held until imem_ready; data dropped, go IDLE; further br_taken only updates PC.
REQ-022 ifid_load SHALL be ~stall | br_taken, combinational.
REQ-023 br_taken SHALL force ifid_instr=32'h0 (flush), overriding stall.
REQ-024 Without br_taken and stall=0: FIFO head presented and popped; FIFO empty presents ifid_instr=32'h0, ifid_pc4=0 (bubble).
REQ-025 stall=1 without br_taken: no pop; FIFO contents and outputs held.
REQ-026 Push and pop in the same cycle SHALL be legal at any count; count unchanged.
REQ-027 The FIFO SHALL never overflow, guaranteed by REQ-016 occupancy gating.
REQ-028 Fetch-to-IF/ID latency SHALL be one cycle after imem_ready when the FIFO was empty and stall=0.

Reset
REQ-029 rst=1 SHALL asynchronously set PC=RESET_PC, state IDLE, FIFO empty, imem_req=0, imem_addr=0.
REQ-030 Reset mid-WAIT SHALL abandon the request; a later imem_ready pulse in IDLE SHALL be ignored.
REQ-031 During reset ifid_load SHALL follow REQ-022; ifid_instr=0, ifid_pc4=0.

Configuration
REQ-032 Macro FETCH_PERF_EN defined: ports bubble_cnt (out 32, stall=0 cycles with FIFO empty and no br_taken) and flush_cnt (out 32, br_taken cycles) SHALL exist, saturating at 32'hFFFF_FFFF, reset to 0.
REQ-033 Macro FETCH_PERF_EN undefined: those ports and counters SHALL be absent, with no other behavioural difference.

Structure
REQ-034 A shared package SHALL hold NOP_INSTR (32'h0), the FSM state encoding, and the {instr, pc4} entry typedef.
REQ-035 The 2-entry buffer SHALL be a sub-module fetch_fifo (push, pop, clear, full, empty, count).

Verification
REQ-036 Reset release, imem_ready 1 cycle after each request, stall=0 -> imem_addr 0,4,8; ifid_instr sequence bubble, I0, I1 with ifid_pc4 4, 8.
REQ-037 FIFO holds 2 entries, stall=1 for 5 cycles -> ifid_load=0, imem_req=0, no request issued; stall release -> 2 pops in order.
REQ-038 br_taken=1, br_target=32'h100 during WAIT, imem_ready 3 cycles later -> data dropped; next imem_addr=32'h100; ifid_instr=0 with ifid_load=1 in the br_taken cycle.
REQ-039 br_taken coincident with imem_ready and stall=1 -> data dropped, ifid_load=1, ifid_instr=0, FSM IDLE next cycle.
REQ-040 PC=32'hFFFF_FFFC fetch -> ifid_pc4=0, next imem_addr=0; rst pulse mid-WAIT -> imem_req=0 immediately, PC=RESET_PC.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage: bubble encoding, request FSM states
// and the {instr, pc4} prefetch entry layout.
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small prefetch buffer holding {instr, pc4} entries between the instruction
// memory and the IF/ID register. Clear wins over push/pop.
module fetch_fifo
  import fetch_stage_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         clear,
  input  logic [ENTRY_W-1:0]           wr_data,
  output logic [ENTRY_W-1:0]           rd_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push_en;
  logic             pop_en;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign rd_data = mem[rd_ptr_reg];

  // A pop frees the slot the push needs, so push is allowed at full when popping.
  assign push_en = push && (!full || pop);
  assign pop_en  = pop && !empty;

  always_ff @(posedge clk) begin
    if (push_en && !clear) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_en) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop_en)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({push_en, pop_en})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one-outstanding-request memory FSM feeding a 2-entry
// prefetch buffer into IF/ID. Optional FETCH_PERF_EN adds bubble/flush counters.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        ifid_load,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] bubble_cnt,
  output logic [31:0] flush_cnt
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  fetch_state_t     state_reg, state_next;
  logic [31:0]      pc_reg, pc_next;
  logic             req_reg, req_next;
  logic [31:0]      addr_reg, addr_next;

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   occupancy;
  fetch_entry_t     push_entry;
  fetch_entry_t     head_entry;
  logic [31:0]      target_aligned;

  assign target_aligned   = word_align(br_target);
  assign occupancy        = {1'b0, fifo_count} + (CNT_W+1)'(state_reg == ST_WAIT);
  assign push_entry.instr = imem_rdata;
  assign push_entry.pc4   = addr_reg + 32'd4;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .clear   (br_taken),
    .wr_data (push_entry),
    .rd_data (head_entry),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      pc_reg    <= RESET_PC;
      req_reg   <= 1'b0;
      addr_reg  <= 32'h0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      req_reg   <= req_next;
      addr_reg  <= addr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    req_next   = req_reg;
    addr_next  = addr_reg;
    fifo_push  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (br_taken) begin
          pc_next = target_aligned;
        end else if (!fifo_full && (occupancy < (CNT_W+1)'(FIFO_DEPTH))) begin
          state_next = ST_WAIT;
          req_next   = 1'b1;
          addr_next  = pc_reg;
          pc_next    = pc_reg + 32'd4;
        end
      end
      ST_WAIT: begin
        if (imem_ready) begin
          state_next = ST_IDLE;
          req_next   = 1'b0;
          fifo_push  = !br_taken;
        end else if (br_taken) begin
          state_next = ST_DISCARD;
        end
        if (br_taken) pc_next = target_aligned;
      end
      ST_DISCARD: begin
        // Request stays up until memory answers; its data belongs to a squashed path.
        if (imem_ready) begin
          state_next = ST_IDLE;
          req_next   = 1'b0;
        end
        if (br_taken) pc_next = target_aligned;
      end
      default: begin
        state_next = ST_IDLE;
        req_next   = 1'b0;
      end
    endcase
  end

  assign imem_req  = req_reg;
  assign imem_addr = addr_reg;

  assign ifid_load = ~stall | br_taken;
  assign fifo_pop  = !br_taken && !stall && !fifo_empty;

  always_comb begin
    ifid_instr = head_entry.instr;
    ifid_pc4   = head_entry.pc4;
    if (br_taken || fifo_empty) begin
      ifid_instr = NOP_INSTR;
      ifid_pc4   = 32'h0;
    end
  end

`ifdef FETCH_PERF_EN
  logic bubble_event;
  assign bubble_event = !stall && fifo_empty && !br_taken;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt <= 32'h0;
      flush_cnt  <= 32'h0;
    end else begin
      if (bubble_event && (bubble_cnt != 32'hFFFF_FFFF)) bubble_cnt <= bubble_cnt + 32'd1;
      if (br_taken && (flush_cnt != 32'hFFFF_FFFF))      flush_cnt  <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: in-order fetch, stall hold, branch discard,
// branch/ready collision, PC wrap and mid-request reset.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        ifid_load;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
`ifdef FETCH_PERF_EN
  logic [31:0] bubble_cnt;
  logic [31:0] flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] I0 = 32'h1111_0013;
  localparam logic [31:0] I1 = 32'h2222_0093;
  localparam logic [31:0] I2 = 32'h3333_0113;
  localparam logic [31:0] I3 = 32'h4444_0193;
  localparam logic [31:0] I4 = 32'h5555_0213;
  localparam logic [31:0] I5 = 32'h6666_0293;
  localparam logic [31:0] I6 = 32'h7777_0313;
  localparam logic [31:0] I7 = 32'h8888_0393;

  always #5 clk = ~clk;

  fetch_stage #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .ifid_load  (ifid_load),
    .ifid_instr (ifid_instr),
    .ifid_pc4   (ifid_pc4)
`ifdef FETCH_PERF_EN
    ,
    .bubble_cnt (bubble_cnt),
    .flush_cnt  (flush_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    stall      = 1'b0;
    br_taken   = 1'b0;
    br_target  = 32'h0;
    imem_ready = 1'b0;
    imem_rdata = 32'h0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_instr", ifid_instr, 0);
    check("rst_pc4", ifid_pc4, 0);
    check("rst_load", ifid_load, 1);
    stall = 1'b1;
    #1;
    check("rst_load_stall", ifid_load, 0);
    stall = 1'b0;
    rst   = 1'b0;

    // In-order fetch: addresses 0,4,8 and instr bubble, I0, I1
    next_cycle; #1;
    check("f0_req", imem_req, 1);
    check("f0_addr", imem_addr, 32'h0);
    check("f0_bubble", ifid_instr, 0);
    imem_ready = 1'b1; imem_rdata = I0;
    next_cycle;
    imem_ready = 1'b0; #1;
    check("f0_req_drop", imem_req, 0);
    check("f0_instr", ifid_instr, I0);
    check("f0_pc4", ifid_pc4, 32'h4);
    check("f0_load", ifid_load, 1);
    next_cycle; #1;
    check("f1_addr", imem_addr, 32'h4);
    check("f1_req", imem_req, 1);
    check("f1_bubble", ifid_instr, 0);
    imem_ready = 1'b1; imem_rdata = I1;
    next_cycle;
    imem_ready = 1'b0; #1;
    check("f1_instr", ifid_instr, I1);
    check("f1_pc4", ifid_pc4, 32'h8);
    next_cycle; #1;
    check("f2_addr", imem_addr, 32'h8);
    check("f2_req", imem_req, 1);

    // Fill both entries under stall, then hold for 5 cycles
    stall = 1'b1; imem_ready = 1'b1; imem_rdata = I2;
    #1;
    check("stall_load", ifid_load, 0);
    next_cycle;
    imem_ready = 1'b0;
    next_cycle; #1;
    check("f3_req", imem_req, 1);
    check("f3_addr", imem_addr, 32'hC);
    imem_ready = 1'b1; imem_rdata = I3;
    next_cycle;
    imem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i != 0) next_cycle;
      #1;
      check("hold_req", imem_req, 0);
      check("hold_load", ifid_load, 0);
      check("hold_instr", ifid_instr, I2);
      check("hold_pc4", ifid_pc4, 32'hC);
    end
    next_cycle;
    stall = 1'b0; #1;
    check("pop0_instr", ifid_instr, I2);
    check("pop0_pc4", ifid_pc4, 32'hC);
    check("pop0_load", ifid_load, 1);
    next_cycle; #1;
    check("pop1_instr", ifid_instr, I3);
    check("pop1_pc4", ifid_pc4, 32'h10);
    check("pop1_req", imem_req, 0);
    next_cycle; #1;
    check("refill_bubble", ifid_instr, 0);
    check("refill_req", imem_req, 1);
    check("refill_addr", imem_addr, 32'h10);

    // Branch during WAIT, memory answers 3 cycles later
    br_taken = 1'b1; br_target = 32'h100; #1;
    check("br_flush_instr", ifid_instr, 0);
    check("br_flush_load", ifid_load, 1);
    next_cycle;
    br_taken = 1'b0; #1;
    check("disc_req", imem_req, 1);
    check("disc_addr", imem_addr, 32'h10);
    next_cycle; #1;
    check("disc_req2", imem_req, 1);
    next_cycle;
    imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    next_cycle;
    imem_ready = 1'b0; #1;
    check("disc_done_req", imem_req, 0);
    check("disc_dropped", ifid_instr, 0);
    next_cycle; #1;
    check("br_addr", imem_addr, 32'h100);
    check("br_req", imem_req, 1);

    // Branch coincident with ready under stall
    br_taken = 1'b1; br_target = 32'h200; imem_ready = 1'b1;
    imem_rdata = 32'hCAFE_F00D; stall = 1'b1; #1;
    check("coll_load", ifid_load, 1);
    check("coll_instr", ifid_instr, 0);
    check("coll_pc4", ifid_pc4, 0);
    next_cycle;
    br_taken = 1'b0; imem_ready = 1'b0; stall = 1'b0; #1;
    check("coll_idle_req", imem_req, 0);
    check("coll_dropped", ifid_instr, 0);
    next_cycle; #1;
    check("coll_addr", imem_addr, 32'h200);
    imem_ready = 1'b1; imem_rdata = I4;
    next_cycle;
    imem_ready = 1'b0; #1;
    check("lat_instr", ifid_instr, I4);
    check("lat_pc4", ifid_pc4, 32'h204);
    next_cycle; #1;
    check("seq_addr", imem_addr, 32'h204);

    // PC wrap at top of address space
    br_taken = 1'b1; br_target = 32'hFFFF_FFFC; imem_ready = 1'b1; imem_rdata = 32'h1234_5678;
    next_cycle;
    br_taken = 1'b0; imem_ready = 1'b0;
    next_cycle; #1;
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    check("wrap_req", imem_req, 1);
    imem_ready = 1'b1; imem_rdata = I5;
    next_cycle;
    imem_ready = 1'b0; #1;
    check("wrap_instr", ifid_instr, I5);
    check("wrap_pc4", ifid_pc4, 32'h0);
    next_cycle; #1;
    check("wrap_next_addr", imem_addr, 32'h0);
    imem_ready = 1'b1; imem_rdata = I6;
    next_cycle;
    imem_ready = 1'b0;
    next_cycle; #1;
    check("pre_rst_addr", imem_addr, 32'h4);
    check("pre_rst_req", imem_req, 1);

    // Reset mid-WAIT; stale ready in IDLE must be ignored
    rst = 1'b1; #1;
    check("midrst_req", imem_req, 0);
    check("midrst_addr", imem_addr, 0);
    check("midrst_instr", ifid_instr, 0);
    next_cycle;
    rst = 1'b0; imem_ready = 1'b1; imem_rdata = 32'hBAD0_BAD0;
`ifdef FETCH_PERF_EN
    check("perf_bubble_rst", bubble_cnt, 0);
    check("perf_flush_rst", flush_cnt, 0);
`endif
    next_cycle;
    imem_ready = 1'b0; #1;
    check("postrst_req", imem_req, 1);
    check("postrst_addr", imem_addr, 32'h0);
    check("postrst_instr", ifid_instr, 0);
    imem_ready = 1'b1; imem_rdata = I7;
    next_cycle;
    imem_ready = 1'b0; #1;
    check("postrst_fetch", ifid_instr, I7);
    check("postrst_pc4", ifid_pc4, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
